// File: rtl/ram_be_pkg.sv
// rtl/ram_be_pkg.sv - shared types and helpers for the byte-enable synchronous RAM
package ram_be_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    localparam int BYTE_W = 8;

    function automatic int lanes(input int width);
        return width / BYTE_W;
    endfunction

endpackage

// File: rtl/ram_be_clear_seq.sv
// rtl/ram_be_clear_seq.sv - clear sequencer that walks every word after reset or on request
module ram_be_clear_seq
    import ram_be_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Exit on the last word so the pointer never needs to wrap.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            ST_IDLE: begin
                if (clr) begin
                    state_nxt = ST_CLEAR;
                    ptr_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                if (ptr == LAST) begin
                    state_nxt = ST_IDLE;
                end else begin
                    ptr_nxt = ptr + 1'b1;
                end
            end
            default: state_nxt = ST_CLEAR;
        endcase
    end

    assign busy     = (state == ST_CLEAR);
    assign clr_we   = busy;
    assign clr_addr = ptr;

endmodule

// File: rtl/ram_be_sync.sv
// rtl/ram_be_sync.sv - byte-enable sync RAM with clear sequencer; RAM_BE_SYNC_PARITY_EN adds per-byte parity
module ram_be_sync
    import ram_be_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [WIDTH/BYTE_W-1:0] we,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [WIDTH-1:0]        D,
    output logic [WIDTH-1:0]        Q,
    input  logic                    clr,
    output logic                    busy
`ifdef RAM_BE_SYNC_PARITY_EN
    ,
    output logic                    perr
`endif
);

    localparam int LANES = lanes(WIDTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    ram_be_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // The clear write owns the array while busy, so user writes only land in IDLE.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (en) begin
            for (int i = 0; i < LANES; i++) begin
                if (we[i]) begin
                    mem[addr][i*BYTE_W +: BYTE_W] <= D[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Nonblocking array update makes same-address read-during-write read-first.
    always_ff @(posedge clk) begin
        if (rst) begin
            Q <= '0;
        end else if (en && !busy) begin
            Q <= mem[addr];
        end
    end

`ifdef RAM_BE_SYNC_PARITY_EN
    logic [LANES-1:0] par_mem [DEPTH];
    logic [LANES-1:0] rd_par;

    always_ff @(posedge clk) begin
        if (clr_we) begin
            par_mem[clr_addr] <= '0;
        end else if (en) begin
            for (int i = 0; i < LANES; i++) begin
                if (we[i]) begin
                    par_mem[addr][i] <= ^D[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    always_comb begin
        rd_par = '0;
        for (int i = 0; i < LANES; i++) begin
            rd_par[i] = ^mem[addr][i*BYTE_W +: BYTE_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perr <= 1'b0;
        end else if (en && !busy) begin
            perr <= |(rd_par ^ par_mem[addr]);
        end else begin
            perr <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_ram_be_sync.sv
// tb/tb_ram_be_sync.sv - directed self-checking bench for ram_be_sync (WIDTH=32, DEPTH=8)
module tb_ram_be_sync;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [3:0]        we;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  D;
    logic [WIDTH-1:0]  Q;
    logic              clr;
    logic              busy;
`ifdef RAM_BE_SYNC_PARITY_EN
    logic              perr;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    ram_be_sync #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .we   (we),
        .addr (addr),
        .D    (D),
        .Q    (Q),
        .clr  (clr),
        .busy (busy)
`ifdef RAM_BE_SYNC_PARITY_EN
        ,
        .perr (perr)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic cyc(input logic r, input logic e, input logic [3:0] w,
                       input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic c);
        rst  = r;
        en   = e;
        we   = w;
        addr = a;
        D    = d;
        clr  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 4'h0, '0, '0, 1'b0);
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] w);
        cyc(1'b0, 1'b1, w, a, d, 1'b0);
    endtask

    task automatic rd_check(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
        cyc(1'b0, 1'b1, 4'h0, a, 32'h0, 1'b0);
        check(tag, Q, exp);
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy && cnt < 50) begin
            idle_cyc();
            cnt++;
        end
    endtask

    initial begin
        int cnt;

        // reset and power-on clear
        cyc(1'b1, 1'b0, 4'h0, '0, '0, 1'b0);
        check("reset_busy", {31'b0, busy}, 32'h1);
        check("reset_q", Q, 32'h0);
        count_busy(cnt);
        check("reset_clear_len", cnt, 8);
        for (int i = 0; i < DEPTH; i++) rd_check("reset_zero", ADDR_W'(i), 32'h0);

        // full-word write and readback
        for (int i = 0; i < DEPTH; i++) wr(ADDR_W'(i), 32'hA5A5_0000 + i, 4'hF);
        for (int i = 0; i < DEPTH; i++) rd_check("word_rb", ADDR_W'(i), 32'hA5A5_0000 + i);

        // byte enables
        wr(3'd3, 32'h1122_3344, 4'hF);
        wr(3'd3, 32'hFFFF_FFFF, 4'b0101);
        rd_check("byte_en", 3'd3, 32'h11FF_33FF);
        wr(3'd3, 32'h0000_0000, 4'b1000);
        rd_check("byte_en_top", 3'd3, 32'h00FF_33FF);

        // en=0 holds Q
        idle_cyc();
        check("en0_hold", Q, 32'h00FF_33FF);

        // read-first collision
        wr(3'd2, 32'h0000_0002, 4'hF);
        wr(3'd2, 32'hDEAD_BEEF, 4'hF);
        check("rdw_first", Q, 32'h0000_0002);
        rd_check("rdw_after", 3'd2, 32'hDEAD_BEEF);

        // mid-operation clear; same-cycle access still happens, clr during clear ignored
        cyc(1'b0, 1'b1, 4'hF, 3'd1, 32'h0000_0055, 1'b1);
        check("clr_busy", {31'b0, busy}, 32'h1);
        check("clr_same_cycle_read", Q, 32'hA5A5_0001);
        cnt = 0;
        while (busy && cnt < 50) begin
            cyc(1'b0, 1'b1, 4'hF, 3'd5, 32'h1234_5678, cnt == 3);
            cnt++;
        end
        check("clr_len", cnt, 8);
        check("clr_q_hold", Q, 32'hA5A5_0001);
        for (int i = 0; i < DEPTH; i++) rd_check("clr_zero", ADDR_W'(i), 32'h0);

        // reset three cycles into a clear
        wr(3'd6, 32'hCAFE_F00D, 4'hF);
        cyc(1'b0, 1'b0, 4'h0, '0, '0, 1'b1);
        idle_cyc();
        idle_cyc();
        cyc(1'b1, 1'b0, 4'h0, '0, '0, 1'b0);
        check("rst_mid_busy", {31'b0, busy}, 32'h1);
        check("rst_mid_q", Q, 32'h0);
        count_busy(cnt);
        check("rst_mid_len", cnt, 8);
        for (int i = 0; i < DEPTH; i++) rd_check("rst_mid_zero", ADDR_W'(i), 32'h0);

`ifdef RAM_BE_SYNC_PARITY_EN
        wr(3'd4, 32'h0102_0304, 4'hF);
        wr(3'd3, 32'h0000_00FF, 4'hF);
        rd_check("par_good_data", 3'd4, 32'h0102_0304);
        check("par_good", {31'b0, perr}, 32'h0);
        dut.par_mem[4][1] = ~dut.par_mem[4][1];
        rd_check("par_bad_data", 3'd4, 32'h0102_0304);
        check("par_flip", {31'b0, perr}, 32'h1);
        rd_check("par_other", 3'd3, 32'h0000_00FF);
        check("par_other_ok", {31'b0, perr}, 32'h0);
        idle_cyc();
        check("par_no_read", {31'b0, perr}, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
